// File: rtl/class_arbiter.sv
// class_arbiter: drains four class FIFOs into one egress FIFO, round-robin, pop-to-push latency 2.
// Optional macro CLASS_ARB_PRIORITY_EN: class 3 wins whenever eligible, classes 0-2 rotate.
module class_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  state,
  input  logic        empty_0,
  input  logic        empty_1,
  input  logic        empty_2,
  input  logic        empty_3,
  input  logic [11:0] data_in_0,
  input  logic [11:0] data_in_1,
  input  logic [11:0] data_in_2,
  input  logic [11:0] data_in_3,
  input  logic        almost_full_out,
  output logic        pop_0,
  output logic        pop_1,
  output logic        pop_2,
  output logic        pop_3,
  output logic        push_out,
  output logic [11:0] data_out,
  output logic [7:0]  cnt_0,
  output logic [7:0]  cnt_1,
  output logic [7:0]  cnt_2,
  output logic [7:0]  cnt_3
);

  logic [3:0]      empty_v;
  logic            clear;
  logic            active;
  logic [3:0]      elig;
  logic [3:0]      rr_elig;
  logic [1:0]      cand;
  logic            grant_valid;
  logic            grant_rr;
  logic [1:0]      grant_idx;
  logic [11:0]     s1_data;

  logic [3:0]      pop_q, pop_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic            s1_valid_q, s1_valid_d;
  logic [1:0]      s1_idx_q, s1_idx_d;
  logic            push_q, push_d;
  logic [1:0]      push_idx_q, push_idx_d;
  logic [11:0]     data_q, data_d;
  logic [3:0][7:0] cnt_q, cnt_d;

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // A class just popped is ineligible: its FIFO empty flag has not caught up yet.
  always_comb begin
    empty_v = {empty_3, empty_2, empty_1, empty_0};
    clear   = reset || (state == 4'b0001);
    active  = (state == 4'b0100) || (state == 4'b1000);
    elig    = {4{active && !almost_full_out}} & ~empty_v & ~pop_q;
  end

  always_comb begin
`ifdef CLASS_ARB_PRIORITY_EN
    rr_elig = elig & 4'b0111;
`else
    rr_elig = elig;
`endif
    grant_valid = 1'b0;
    grant_rr    = 1'b0;
    grant_idx   = last_grant_q;
    cand        = last_grant_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant_q + 2'(i);
      if (!grant_valid && rr_elig[cand]) begin
        grant_valid = 1'b1;
        grant_rr    = 1'b1;
        grant_idx   = cand;
      end
    end
`ifdef CLASS_ARB_PRIORITY_EN
    // Class 3 overrides the rotation and leaves the pointer for classes 0-2 untouched.
    if (elig[3]) begin
      grant_valid = 1'b1;
      grant_rr    = 1'b0;
      grant_idx   = 2'd3;
    end
`endif
  end

  always_comb begin
    case (s1_idx_q)
      2'd0:    s1_data = data_in_0;
      2'd1:    s1_data = data_in_1;
      2'd2:    s1_data = data_in_2;
      default: s1_data = data_in_3;
    endcase
  end

  always_comb begin
    pop_d        = 4'b0000;
    last_grant_d = last_grant_q;
    if (grant_valid) begin
      pop_d = 4'b0001 << grant_idx;
      if (grant_rr) begin
        last_grant_d = grant_idx;
      end
    end
    s1_valid_d = |pop_q;
    s1_idx_d   = onehot_idx(pop_q);
    push_d     = s1_valid_q;
    push_idx_d = s1_idx_q;
    data_d     = data_q;
    if (s1_valid_q) begin
      data_d = s1_data;
    end
    cnt_d = cnt_q;
    if (push_q) begin
      cnt_d[push_idx_q] = cnt_q[push_idx_q] + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      pop_q        <= 4'b0000;
      last_grant_q <= 2'd3;
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= 2'd0;
      push_q       <= 1'b0;
      push_idx_q   <= 2'd0;
      data_q       <= 12'h000;
      cnt_q        <= '0;
    end else begin
      pop_q        <= pop_d;
      last_grant_q <= last_grant_d;
      s1_valid_q   <= s1_valid_d;
      s1_idx_q     <= s1_idx_d;
      push_q       <= push_d;
      push_idx_q   <= push_idx_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pop_0    = pop_q[0];
  assign pop_1    = pop_q[1];
  assign pop_2    = pop_q[2];
  assign pop_3    = pop_q[3];
  assign push_out = push_q;
  assign data_out = data_q;
  assign cnt_0    = cnt_q[0];
  assign cnt_1    = cnt_q[1];
  assign cnt_2    = cnt_q[2];
  assign cnt_3    = cnt_q[3];

endmodule

// File: tb/tb_class_arbiter.sv
// Directed self-checking bench for class_arbiter; expected values are hand-derived per step.
`timescale 1ns/1ps
module tb_class_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic        empty_0, empty_1, empty_2, empty_3;
  logic [11:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic        almost_full_out;
  logic        pop_0, pop_1, pop_2, pop_3;
  logic        push_out;
  logic [11:0] data_out;
  logic [7:0]  cnt_0, cnt_1, cnt_2, cnt_3;
  logic [3:0]  pops_v;

  int n_cmp = 0;
  int n_err = 0;
  int npop  = 0;

  localparam logic [11:0] D0 = 12'h0A1;
  localparam logic [11:0] D1 = 12'h4B2;
  localparam logic [11:0] D2 = 12'h8C3;
  localparam logic [11:0] D3 = 12'hCD4;

`ifdef CLASS_ARB_PRIORITY_EN
  logic [3:0]  t1_pop  [8] = '{4'h8, 4'h1, 4'h8, 4'h2, 4'h8, 4'h4, 4'h8, 4'h1};
  logic        t1_push [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [11:0] t1_data [8] = '{12'h000, 12'h000, D3, D0, D3, D1, D3, D2};
  localparam logic [3:0] H_POP1 = 4'h8;
  localparam logic [3:0] H_POP2 = 4'h1;
  localparam logic [3:0] H_POP3 = 4'h8;
  localparam logic [3:0] H_FIRST = 4'h8;
`else
  logic [3:0]  t1_pop  [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
  logic        t1_push [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [11:0] t1_data [8] = '{12'h000, 12'h000, D0, D1, D2, D3, D0, D0};
  localparam logic [3:0] H_POP1 = 4'h1;
  localparam logic [3:0] H_POP2 = 4'h2;
  localparam logic [3:0] H_POP3 = 4'h4;
  localparam logic [3:0] H_FIRST = 4'h1;
`endif
  logic [3:0]  t3_pop  [9] = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h4};
  logic        t3_push [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  class_arbiter dut (
    .clk(clk), .reset(reset), .state(state),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2), .empty_3(empty_3),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .almost_full_out(almost_full_out),
    .pop_0(pop_0), .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3),
    .push_out(push_out), .data_out(data_out),
    .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3)
  );

  assign pops_v = {pop_3, pop_2, pop_1, pop_0};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_empty(input logic [3:0] e);
    {empty_3, empty_2, empty_1, empty_0} = e;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnts(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                          input logic [7:0] c2, input logic [7:0] c3);
    chk({tag, "_cnt0"}, 32'(cnt_0), 32'(c0));
    chk({tag, "_cnt1"}, 32'(cnt_1), 32'(c1));
    chk({tag, "_cnt2"}, 32'(cnt_2), 32'(c2));
    chk({tag, "_cnt3"}, 32'(cnt_3), 32'(c3));
  endtask

  initial begin
    reset = 1'b1;
    state = 4'b0000;
    set_empty(4'hF);
    almost_full_out = 1'b0;
    data_in_0 = D0;
    data_in_1 = D1;
    data_in_2 = D2;
    data_in_3 = D3;
    step();
    step();
    chk("rst_pop", 32'(pops_v), 32'h0);
    chk("rst_push", 32'(push_out), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk_cnts("rst", 8'd0, 8'd0, 8'd0, 8'd0);

    // All FIFOs non-empty: rotation (or class-3 priority), push two cycles after each pop.
    reset = 1'b0;
    state = 4'b0100;
    set_empty(4'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t1_pop%0d", i), 32'(pops_v), 32'(t1_pop[i]));
      chk($sformatf("t1_push%0d", i), 32'(push_out), 32'(t1_push[i]));
      chk($sformatf("t1_data%0d", i), 32'(data_out), 32'(t1_data[i]));
`ifndef CLASS_ARB_PRIORITY_EN
      if (i == 4) state = 4'b0010;
`endif
    end
`ifndef CLASS_ARB_PRIORITY_EN
    chk_cnts("t1", 8'd2, 8'd1, 8'd1, 8'd1);
`endif

    // Init state clears like reset.
    state = 4'b0001;
    step();
    chk("init_push", 32'(push_out), 32'h0);
    chk("init_data", 32'(data_out), 32'h0);
    chk_cnts("init", 8'd0, 8'd0, 8'd0, 8'd0);

    // Only class 2 non-empty: pop every other cycle.
    state = 4'b1000;
    set_empty(4'b1011);
    data_in_2 = 12'h8A5;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t2_pop%0d", i), 32'(pops_v), (i % 2 == 0) ? 32'h4 : 32'h0);
      chk($sformatf("t2_push%0d", i), 32'(push_out), (i >= 2 && i % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("t2_data%0d", i), 32'(data_out), (i >= 2) ? 32'h8A5 : 32'h0);
    end
    chk_cnts("t2", 8'd0, 8'd0, 8'd3, 8'd0);

    // Almost-full raised the cycle after a pop, then released.
    reset = 1'b1;
    step();
    reset = 1'b0;
    state = 4'b0100;
    data_in_2 = 12'h9C3;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t3_pop%0d", i), 32'(pops_v), 32'(t3_pop[i]));
      chk($sformatf("t3_push%0d", i), 32'(push_out), 32'(t3_push[i]));
      chk($sformatf("t3_data%0d", i), 32'(data_out), (i >= 2) ? 32'h9C3 : 32'h0);
      if (i == 1) almost_full_out = 1'b1;
      if (i == 5) almost_full_out = 1'b0;
    end

    // Reset with words in flight.
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_empty(4'h0);
    step();
    chk("t4_pop1", 32'(pops_v), 32'(H_POP1));
    step();
    chk("t4_pop2", 32'(pops_v), 32'(H_POP2));
    step();
    chk("t4_pop3", 32'(pops_v), 32'(H_POP3));
    chk("t4_push3", 32'(push_out), 32'h1);
    reset = 1'b1;
    step();
    chk("t4_rpop", 32'(pops_v), 32'h0);
    chk("t4_rpush", 32'(push_out), 32'h0);
    chk_cnts("t4", 8'd0, 8'd0, 8'd0, 8'd0);
    reset = 1'b0;
    step();
    chk("t4_first", 32'(pops_v), 32'(H_FIRST));
    chk("t4_push5", 32'(push_out), 32'h0);

    // 256 class-1 words: counter wraps to zero.
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_empty(4'b1101);
    npop = 0;
    for (int i = 1; i <= 514; i++) begin
      step();
      if (pop_1) npop++;
      if (i == 511) set_empty(4'hF);
      if (i == 512) chk("t5_cnt1_255", 32'(cnt_1), 32'd255);
    end
    chk("t5_npop", 32'(npop), 32'd256);
    chk_cnts("t5", 8'd0, 8'd0, 8'd0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
